// File: rtl/asyn_fifo.sv
// Single-clock FIFO of 2**ADDR_WIDTH words with registered read data and full/empty flags.
// Define ASYN_FIFO_STATUS_EN to add sticky overflow/underflow flags and an occupancy count.
module asyn_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Clear_in,
  input  logic                  WriteEn_in,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic                  Full_out,
  input  logic                  ReadEn_in,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Empty_out
`ifdef ASYN_FIFO_STATUS_EN
  ,
  output logic                  Overflow_out,
  output logic                  Underflow_out,
  output logic [ADDR_WIDTH:0]   Count_out
`endif
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr, rptr;
  logic                  do_wr, do_rd;

  // Wrap bit distinguishes full from empty when the address bits coincide
  assign Empty_out = (wptr == rptr);
  assign Full_out  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                     (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
  assign do_wr = WriteEn_in && !Full_out;
  assign do_rd = ReadEn_in && !Empty_out;

  always_ff @(posedge Clk) begin
    if (do_wr && !Clear_in) mem[wptr[ADDR_WIDTH-1:0]] <= Data_in;
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wptr     <= '0;
      rptr     <= '0;
      Data_out <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) begin
        Data_out <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr     <= rptr + PTR_ONE;
      end
    end
  end

`ifdef ASYN_FIFO_STATUS_EN
  assign Count_out = wptr - rptr;

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      Overflow_out  <= 1'b0;
      Underflow_out <= 1'b0;
    end else begin
      if (WriteEn_in && Full_out) Overflow_out  <= 1'b1;
      if (ReadEn_in && Empty_out) Underflow_out <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_asyn_fifo.sv
// Directed self-checking bench for asyn_fifo: order, flags, boundaries and clear.
`timescale 1ns/1ps
module tb_asyn_fifo;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Clear_in = 1'b0;
  logic          WriteEn_in = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic          Full_out;
  logic          ReadEn_in = 1'b0;
  logic [DW-1:0] Data_out;
  logic          Empty_out;
`ifdef ASYN_FIFO_STATUS_EN
  logic          Overflow_out, Underflow_out;
  logic [AW:0]   Count_out;
`endif

  int checks = 0;
  int passed = 0;

  asyn_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Clear_in(Clear_in), .WriteEn_in(WriteEn_in), .Data_in(Data_in),
    .Full_out(Full_out), .ReadEn_in(ReadEn_in), .Data_out(Data_out), .Empty_out(Empty_out)
`ifdef ASYN_FIFO_STATUS_EN
    , .Overflow_out(Overflow_out), .Underflow_out(Underflow_out), .Count_out(Count_out)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clear_in = 1'b1; WriteEn_in = 1'b0; ReadEn_in = 1'b0;
    tick();
    Clear_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL reset_empty: got %b want 1", Empty_out); else passed++;
    checks++; if (Full_out !== 1'b0) $display("FAIL reset_full: got %b want 0", Full_out); else passed++;
    checks++; if (Data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", Data_out); else passed++;
  endtask

  task automatic test_burst();
    logic [DW-1:0] vals [10] = '{8'd3, 8'd7, 8'd0, 8'd15, 8'd9, 8'd1, 8'd12, 8'd5, 8'd8, 8'd14};
    for (int i = 0; i < 10; i++) begin
      WriteEn_in = 1'b1; Data_in = vals[i];
      tick();
    end
    WriteEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b0) $display("FAIL burst_not_empty: got %b want 0", Empty_out); else passed++;
    for (int i = 0; i < 10; i++) begin
      ReadEn_in = 1'b1;
      tick();
      checks++; if (Data_out !== vals[i]) $display("FAIL burst_data[%0d]: got %h want %h", i, Data_out, vals[i]); else passed++;
    end
    ReadEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL burst_empty_after: got %b want 1", Empty_out); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      WriteEn_in = 1'b1; Data_in = 8'h10 + 8'(i);
      tick();
      if (i == 14) begin
        checks++; if (Full_out !== 1'b0) $display("FAIL full_early: got %b want 0", Full_out); else passed++;
      end
    end
    checks++; if (Full_out !== 1'b1) $display("FAIL full_set: got %b want 1", Full_out); else passed++;
    Data_in = 8'hAA;
    tick();
    WriteEn_in = 1'b0;
    checks++; if (Full_out !== 1'b1) $display("FAIL full_after_drop: got %b want 1", Full_out); else passed++;
`ifdef ASYN_FIFO_STATUS_EN
    checks++; if (Overflow_out !== 1'b1) $display("FAIL overflow: got %b want 1", Overflow_out); else passed++;
`endif
    for (int i = 0; i < 16; i++) begin
      ReadEn_in = 1'b1;
      tick();
      checks++; if (Data_out !== 8'h10 + 8'(i)) $display("FAIL full_data[%0d]: got %h want %h", i, Data_out, 8'h10 + 8'(i)); else passed++;
      if (i == 0) begin
        checks++; if (Full_out !== 1'b0) $display("FAIL full_clear_on_read: got %b want 0", Full_out); else passed++;
      end
    end
    ReadEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL full_drained_empty: got %b want 1", Empty_out); else passed++;
  endtask

  task automatic test_underflow();
    ReadEn_in = 1'b1;
    tick();
    tick();
    ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h1F) $display("FAIL underflow_hold: got %h want 1f", Data_out); else passed++;
    checks++; if (Empty_out !== 1'b1) $display("FAIL underflow_empty: got %b want 1", Empty_out); else passed++;
`ifdef ASYN_FIFO_STATUS_EN
    checks++; if (Underflow_out !== 1'b1) $display("FAIL underflow_flag: got %b want 1", Underflow_out); else passed++;
`endif
    WriteEn_in = 1'b1; Data_in = 8'h55;
    tick();
    WriteEn_in = 1'b0; ReadEn_in = 1'b1;
    tick();
    ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h55) $display("FAIL underflow_rptr: got %h want 55", Data_out); else passed++;
  endtask

  task automatic test_simul_empty();
    WriteEn_in = 1'b1; ReadEn_in = 1'b1; Data_in = 8'h66;
    tick();
    WriteEn_in = 1'b0; ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h55) $display("FAIL simul_empty_no_fallthru: got %h want 55", Data_out); else passed++;
    checks++; if (Empty_out !== 1'b0) $display("FAIL simul_empty_wrote: got %b want 0", Empty_out); else passed++;
    ReadEn_in = 1'b1;
    tick();
    ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h66) $display("FAIL simul_empty_data: got %h want 66", Data_out); else passed++;
    checks++; if (Empty_out !== 1'b1) $display("FAIL simul_empty_after: got %b want 1", Empty_out); else passed++;
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) begin
      WriteEn_in = 1'b1; Data_in = 8'h80 + 8'(i);
      tick();
    end
    ReadEn_in = 1'b1; Data_in = 8'h99;
    tick();
    WriteEn_in = 1'b0;
    checks++; if (Data_out !== 8'h80) $display("FAIL simul_full_read: got %h want 80", Data_out); else passed++;
    checks++; if (Full_out !== 1'b0) $display("FAIL simul_full_write_dropped: got %b want 0", Full_out); else passed++;
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++; if (Data_out !== 8'h80 + 8'(i)) $display("FAIL simul_full_data[%0d]: got %h want %h", i, Data_out, 8'h80 + 8'(i)); else passed++;
    end
    ReadEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL simul_full_empty: got %b want 1", Empty_out); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      WriteEn_in = 1'b1; Data_in = 8'h20 + 8'(i);
      tick();
    end
    ReadEn_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      Data_in = 8'h40 + 8'(k);
      tick();
      exp = (k < 8) ? 8'h20 + 8'(k) : 8'h40 + 8'(k - 8);
      checks++; if (Data_out !== exp) $display("FAIL b2b_data[%0d]: got %h want %h", k, Data_out, exp); else passed++;
      checks++; if (Full_out !== 1'b0 || Empty_out !== 1'b0)
        $display("FAIL b2b_flags[%0d]: got full=%b empty=%b want 0 0", k, Full_out, Empty_out); else passed++;
    end
    WriteEn_in = 1'b0;
    for (int k = 12; k < 20; k++) begin
      tick();
      checks++; if (Data_out !== 8'h40 + 8'(k)) $display("FAIL b2b_drain[%0d]: got %h want %h", k, Data_out, 8'h40 + 8'(k)); else passed++;
    end
    ReadEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL b2b_empty: got %b want 1", Empty_out); else passed++;
  endtask

  task automatic test_clear_midburst();
    for (int i = 0; i < 5; i++) begin
      WriteEn_in = 1'b1; Data_in = 8'hC0 + 8'(i);
      tick();
    end
    Clear_in = 1'b1; ReadEn_in = 1'b1; Data_in = 8'hEE;
    tick();
    Clear_in = 1'b0; WriteEn_in = 1'b0;
    checks++; if (Empty_out !== 1'b1) $display("FAIL clear_empty: got %b want 1", Empty_out); else passed++;
    checks++; if (Full_out !== 1'b0) $display("FAIL clear_full: got %b want 0", Full_out); else passed++;
    checks++; if (Data_out !== 8'h00) $display("FAIL clear_data: got %h want 00", Data_out); else passed++;
    Data_in = 'x;
    tick();
    ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h00) $display("FAIL clear_read_after: got %h want 00", Data_out); else passed++;
    checks++; if (Empty_out !== 1'b1) $display("FAIL clear_x_ignored: got %b want 1", Empty_out); else passed++;
`ifdef ASYN_FIFO_STATUS_EN
    checks++; if (Count_out !== 5'd0) $display("FAIL clear_count: got %0d want 0", Count_out); else passed++;
`endif
    WriteEn_in = 1'b1; Data_in = 8'h77;
    tick();
    WriteEn_in = 1'b0; ReadEn_in = 1'b1;
    tick();
    ReadEn_in = 1'b0;
    checks++; if (Data_out !== 8'h77) $display("FAIL clear_new_word: got %h want 77", Data_out); else passed++;
    checks++; if (Empty_out !== 1'b1) $display("FAIL clear_new_empty: got %b want 1", Empty_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_full();
    test_underflow();
    test_simul_empty();
    test_simul_full();
    test_back_to_back();
    test_clear_midburst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
